// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle accumulator ALU: opcodes, FSM states, flag bit positions.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_LOAD  = 4'h1,
    OP_ADD   = 4'h2,
    OP_SUB   = 4'h3,
    OP_AND   = 4'h4,
    OP_OR    = 4'h5,
    OP_XOR   = 4'h6,
    OP_NOT   = 4'h7,
    OP_SHR   = 4'h8,
    OP_SHL   = 4'h9,
    OP_LDI   = 4'hA,
    OP_ADDI  = 4'hB,
    OP_STORE = 4'hC,
    OP_ASRN  = 4'hD,
    OP_MUL   = 4'hE,
    OP_PASS  = 4'hF
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Opcode fields wider than four bits map codes above 15 onto pass-A.
  function automatic opcode_t decode_op(input logic [31:0] field);
    logic [31:0] f;
    f = field;
    return (f < 32'd16) ? opcode_t'(f[3:0]) : OP_PASS;
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative signed multiplier: shift-add on magnitudes over DATA_SIZE cycles (built only with ALU_MUL_EN).
module alu_mul_seq
  #(parameter int DATA_SIZE = 8)
  (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DATA_SIZE-1:0] a,
    input  logic [DATA_SIZE-1:0] b,
    output logic                 done,
    output logic [DATA_SIZE-1:0] prod,
    output logic                 ovf
  );

  localparam int W  = DATA_SIZE;
  localparam int CW = $clog2(DATA_SIZE);

  logic              busy_q, busy_d;
  logic              neg_q, neg_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*W-1:0]    mcand_q, mcand_d;
  logic [2*W-1:0]    acc_q, acc_d;
  logic [W-1:0]      mplier_q, mplier_d;
  logic [W-1:0]      a_mag, b_mag;
  logic [2*W-1:0]    acc_nx, full;

  always_comb begin
    a_mag  = a[W-1] ? -a : a;
    b_mag  = b[W-1] ? -b : b;
    acc_nx = acc_q + (mplier_q[0] ? mcand_q : '0);
    full   = neg_q ? -acc_nx : acc_nx;
    done   = busy_q && (cnt_q == CW'(W-1));
    prod   = full[W-1:0];
    // Fits DATA_SIZE signed only when the upper half plus the sign bit are all equal.
    ovf    = !((&full[2*W-1:W-1]) || !(|full[2*W-1:W-1]));

    busy_d   = busy_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (start) begin
      busy_d   = 1'b1;
      neg_d    = a[W-1] ^ b[W-1];
      cnt_d    = '0;
      mcand_d  = (2*W)'(a_mag);
      mplier_d = b_mag;
      acc_d    = '0;
    end else if (busy_q) begin
      acc_d    = acc_nx;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (done) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q   <= 1'b0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      busy_q   <= busy_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle accumulator ALU with registered result/flags and valid/ready on both sides.
// Define ALU_MUL_EN to build the iterative multiplier for opcode 1110; otherwise it passes A.
module alu_mc
  import alu_pkg::*;
  #(
    parameter int DATA_SIZE   = 8,
    parameter int OPCODE_SIZE = 4,
    parameter int INSTR_SIZE  = 12
  )
  (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [INSTR_SIZE-1:0] instr,
    input  logic [DATA_SIZE-1:0]  acc,
    input  logic [DATA_SIZE-1:0]  mem_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_SIZE-1:0]  alu_out,
    output logic                  we_alu,
    output logic [3:0]            flags
  );

  localparam int W     = DATA_SIZE;
  localparam int IMM_W = INSTR_SIZE - OPCODE_SIZE;
  localparam int CW    = $clog2(DATA_SIZE);

  state_t           state_q, state_d;
  opcode_t          op_q, op_d, op_dec;
  logic [W-1:0]     res_q, res_d;
  logic [3:0]       flags_q, flags_d;
  logic             we_q, we_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [OPCODE_SIZE-1:0] op_field;
  logic [W-1:0]     imm_ext, alu_res, asrn_sh;
  logic [W:0]       sum;
  logic             alu_c, alu_v, accept;

`ifdef ALU_MUL_EN
  logic             mul_start, mul_done, mul_ovf;
  logic [W-1:0]     mul_prod;

  assign mul_start = accept && (op_dec == OP_MUL);

  alu_mul_seq #(.DATA_SIZE(DATA_SIZE)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .a     (acc),
    .b     (mem_data),
    .done  (mul_done),
    .prod  (mul_prod),
    .ovf   (mul_ovf)
  );
`endif

  function automatic logic [3:0] mk_flags(input logic [W-1:0] r, input logic c, input logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_Z] = (r == '0);
    f[FLAG_N] = r[W-1];
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

  // Single-cycle datapath, evaluated on the live operands so the result is captured at accept.
  always_comb begin
    op_field = instr[INSTR_SIZE-1 -: OPCODE_SIZE];
    op_dec   = decode_op(32'(op_field));
    imm_ext  = W'($signed(instr[IMM_W-1:0]));
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    sum      = '0;
    alu_res  = acc;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    unique case (op_dec)
      OP_LOAD:  alu_res = mem_data;
      OP_ADD: begin
        sum     = {1'b0, acc} + {1'b0, mem_data};
        alu_res = sum[W-1:0];
        alu_c   = sum[W];
        alu_v   = (acc[W-1] == mem_data[W-1]) && (alu_res[W-1] != acc[W-1]);
      end
      OP_SUB: begin
        sum     = {1'b0, acc} - {1'b0, mem_data};
        alu_res = sum[W-1:0];
        alu_c   = !sum[W];
        alu_v   = (acc[W-1] != mem_data[W-1]) && (alu_res[W-1] != acc[W-1]);
      end
      OP_AND:   alu_res = acc & mem_data;
      OP_OR:    alu_res = acc | mem_data;
      OP_XOR:   alu_res = acc ^ mem_data;
      OP_NOT:   alu_res = ~acc;
      OP_SHR: begin
        alu_res = {1'b0, acc[W-1:1]};
        alu_c   = acc[0];
      end
      OP_SHL: begin
        alu_res = {acc[W-2:0], 1'b0};
        alu_c   = acc[W-1];
      end
      OP_LDI:   alu_res = imm_ext;
      OP_ADDI: begin
        sum     = {1'b0, acc} + {1'b0, imm_ext};
        alu_res = sum[W-1:0];
        alu_c   = sum[W];
        alu_v   = (acc[W-1] == imm_ext[W-1]) && (alu_res[W-1] != acc[W-1]);
      end
      default:  alu_res = acc;
    endcase
  end

  always_comb begin
    in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    accept   = in_valid && in_ready;
    asrn_sh  = {res_q[W-1], res_q[W-1:1]};

    state_d  = state_q;
    op_d     = op_q;
    res_d    = res_q;
    flags_d  = flags_q;
    we_d     = we_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      BUSY: begin
        if (op_q == OP_ASRN) begin
          res_d = asrn_sh;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = DONE;
            flags_d = mk_flags(asrn_sh, res_q[0], 1'b0);
          end
        end
`ifdef ALU_MUL_EN
        else if (mul_done) begin
          state_d = DONE;
          res_d   = mul_prod;
          flags_d = mk_flags(mul_prod, 1'b0, mul_ovf);
        end
`endif
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          we_d    = 1'b0;
        end
      end
      default: ;
    endcase

    if (accept) begin
      op_d = op_dec;
      we_d = (op_dec == OP_STORE);
      if ((op_dec == OP_ASRN) && (imm_ext[CW-1:0] != '0)) begin
        state_d = BUSY;
        res_d   = acc;
        cnt_d   = imm_ext[CW-1:0];
      end
`ifdef ALU_MUL_EN
      else if (op_dec == OP_MUL) begin
        state_d = BUSY;
      end
`endif
      else begin
        state_d = DONE;
        res_d   = alu_res;
        flags_d = mk_flags(alu_res, alu_c, alu_v);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignment only; the comb blocks above use blocking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_NOP;
      res_q   <= '0;
      flags_q <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign alu_out   = res_q;
  assign flags     = flags_q;
  assign we_alu    = we_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed-vector bench for alu_mc (DATA_SIZE=8, OPCODE_SIZE=4, INSTR_SIZE=12); honours ALU_MUL_EN.
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] instr;
  logic [7:0]  acc;
  logic [7:0]  mem_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  alu_out;
  logic        we_alu;
  logic [3:0]  flags;

  int vecs = 0;
  int errs = 0;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] imm;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [3:0] fl;
    logic [7:0] lat;
    logic [7:0] bsy;
    logic       we;
  } vec_t;

  alu_mc #(.DATA_SIZE(8), .OPCODE_SIZE(4), .INSTR_SIZE(12)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .acc       (acc),
    .mem_data  (mem_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_out   (alu_out),
    .we_alu    (we_alu),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  // Issue one instruction, then count cycles to out_valid and cycles spent with in_ready low.
  task automatic do_op(input logic [3:0] op, input logic [7:0] imm, input logic [7:0] a,
                       input logic [7:0] b, output int lat, output int bsy);
    int guard;
    @(negedge clk);
    instr    = {op, imm};
    acc      = a;
    mem_data = b;
    in_valid = 1'b1;
    guard    = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    instr    = 12'h000;
    acc      = 8'hA5;
    mem_data = 8'h5A;
    lat      = 0;
    bsy      = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!in_ready) bsy++;
    end while (!out_valid && lat < 100);
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; instr = '0; acc = '0; mem_data = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    vecs++;
    if ({out_valid, alu_out, flags, we_alu} !== {1'b0, 8'h00, 4'h0, 1'b0}) begin
      errs++;
      $display("FAIL reset: valid=%b out=%h flags=%b we=%b, expected all zero",
               out_valid, alu_out, flags, we_alu);
    end
    rst = 1'b0;
    @(negedge clk);
    vecs++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errs++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b, expected 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_single_cycle;
    int lat, bsy;
    vec_t tbl [16] = '{
      '{4'h2, 8'h00, 8'h7F, 8'h01, 8'h80, 4'b0101, 8'd1, 8'd0, 1'b0},
      '{4'h3, 8'h00, 8'h05, 8'h05, 8'h00, 4'b1010, 8'd1, 8'd0, 1'b0},
      '{4'h3, 8'h00, 8'h03, 8'h05, 8'hFE, 4'b0100, 8'd1, 8'd0, 1'b0},
      '{4'h2, 8'h00, 8'hFF, 8'h01, 8'h00, 4'b1010, 8'd1, 8'd0, 1'b0},
      '{4'h3, 8'h00, 8'h80, 8'h01, 8'h7F, 4'b0011, 8'd1, 8'd0, 1'b0},
      '{4'h4, 8'h00, 8'hF0, 8'h3C, 8'h30, 4'b0000, 8'd1, 8'd0, 1'b0},
      '{4'h5, 8'h00, 8'hF0, 8'h0C, 8'hFC, 4'b0100, 8'd1, 8'd0, 1'b0},
      '{4'h6, 8'h00, 8'hAA, 8'hAA, 8'h00, 4'b1000, 8'd1, 8'd0, 1'b0},
      '{4'h7, 8'h00, 8'h0F, 8'h00, 8'hF0, 4'b0100, 8'd1, 8'd0, 1'b0},
      '{4'h8, 8'h00, 8'h81, 8'h00, 8'h40, 4'b0010, 8'd1, 8'd0, 1'b0},
      '{4'h9, 8'h00, 8'h81, 8'h00, 8'h02, 4'b0010, 8'd1, 8'd0, 1'b0},
      '{4'hA, 8'hFB, 8'h00, 8'h00, 8'hFB, 4'b0100, 8'd1, 8'd0, 1'b0},
      '{4'hB, 8'hFF, 8'h10, 8'h00, 8'h0F, 4'b0010, 8'd1, 8'd0, 1'b0},
      '{4'h1, 8'h00, 8'h77, 8'h00, 8'h00, 4'b1000, 8'd1, 8'd0, 1'b0},
      '{4'h0, 8'h00, 8'h55, 8'h00, 8'h55, 4'b0000, 8'd1, 8'd0, 1'b0},
      '{4'hF, 8'h00, 8'h80, 8'h00, 8'h80, 4'b0100, 8'd1, 8'd0, 1'b0}
    };
    for (int i = 0; i < 16; i++) begin
      do_op(tbl[i].op, tbl[i].imm, tbl[i].a, tbl[i].b, lat, bsy);
      vecs++;
      if ({alu_out, flags, we_alu, 8'(lat), 8'(bsy)} !==
          {tbl[i].res, tbl[i].fl, tbl[i].we, tbl[i].lat, tbl[i].bsy}) begin
        errs++;
        $display("FAIL single op=%h #%0d: out=%h flags=%b we=%b lat=%0d busy=%0d, expected out=%h flags=%b we=%b lat=%0d busy=%0d",
                 tbl[i].op, i, alu_out, flags, we_alu, lat, bsy,
                 tbl[i].res, tbl[i].fl, tbl[i].we, tbl[i].lat, tbl[i].bsy);
      end
    end
  endtask

  task automatic test_asrn;
    int lat, bsy;
    vec_t tbl [5] = '{
      '{4'hD, 8'h03, 8'h80, 8'h00, 8'hF0, 4'b0100, 8'd4, 8'd3, 1'b0},
      '{4'hD, 8'h00, 8'h80, 8'h00, 8'h80, 4'b0100, 8'd1, 8'd0, 1'b0},
      '{4'hD, 8'h01, 8'h85, 8'h00, 8'hC2, 4'b0110, 8'd2, 8'd1, 1'b0},
      '{4'hD, 8'h0A, 8'h40, 8'h00, 8'h10, 4'b0000, 8'd3, 8'd2, 1'b0},
      '{4'hD, 8'h07, 8'h7F, 8'h00, 8'h00, 4'b1010, 8'd8, 8'd7, 1'b0}
    };
    for (int i = 0; i < 5; i++) begin
      do_op(tbl[i].op, tbl[i].imm, tbl[i].a, tbl[i].b, lat, bsy);
      vecs++;
      if ({alu_out, flags, 8'(lat), 8'(bsy)} !== {tbl[i].res, tbl[i].fl, tbl[i].lat, tbl[i].bsy}) begin
        errs++;
        $display("FAIL asrn #%0d: out=%h flags=%b lat=%0d busy=%0d, expected out=%h flags=%b lat=%0d busy=%0d",
                 i, alu_out, flags, lat, bsy, tbl[i].res, tbl[i].fl, tbl[i].lat, tbl[i].bsy);
      end
    end
  endtask

  task automatic test_backpressure;
    @(negedge clk);
    out_ready = 1'b0;
    instr     = {4'h2, 8'h00};
    acc       = 8'h20;
    mem_data  = 8'h22;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    instr    = {4'h1, 8'h00};
    acc      = 8'h00;
    mem_data = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vecs++;
      if ({out_valid, in_ready, alu_out, flags} !== {1'b1, 1'b0, 8'h42, 4'b0000}) begin
        errs++;
        $display("FAIL backpressure cyc%0d: valid=%b in_ready=%b out=%h flags=%b, expected 1 0 42 0000",
                 i, out_valid, in_ready, alu_out, flags);
      end
    end
    out_ready = 1'b1;
    #1;
    vecs++;
    if (in_ready !== 1'b1) begin
      errs++;
      $display("FAIL bp_release_ready: in_ready=%b, expected 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    vecs++;
    if ({out_valid, alu_out, flags} !== {1'b1, 8'h5A, 4'b0000}) begin
      errs++;
      $display("FAIL bp_next_op: valid=%b out=%h flags=%b, expected 1 5a 0000", out_valid, alu_out, flags);
    end
  endtask

  task automatic test_store;
    int lat, bsy;
    do_op(4'hC, 8'h00, 8'h3C, 8'h00, lat, bsy);
    vecs++;
    if ({out_valid, alu_out, we_alu, 8'(lat)} !== {1'b1, 8'h3C, 1'b1, 8'd1}) begin
      errs++;
      $display("FAIL store: valid=%b out=%h we=%b lat=%0d, expected 1 3c 1 1", out_valid, alu_out, we_alu, lat);
    end
    @(negedge clk);
    vecs++;
    if ({out_valid, we_alu} !== 2'b00) begin
      errs++;
      $display("FAIL store_retired: valid=%b we=%b, expected 0 0", out_valid, we_alu);
    end
    do_op(4'h1, 8'h00, 8'h00, 8'h11, lat, bsy);
    vecs++;
    if ({out_valid, alu_out, we_alu} !== {1'b1, 8'h11, 1'b0}) begin
      errs++;
      $display("FAIL load_after_store: valid=%b out=%h we=%b, expected 1 11 0", out_valid, alu_out, we_alu);
    end
  endtask

  task automatic test_mul;
    int lat, bsy;
`ifdef ALU_MUL_EN
    vec_t tbl [3] = '{
      '{4'hE, 8'h00, 8'hFD, 8'h07, 8'hEB, 4'b0100, 8'd9, 8'd8, 1'b0},
      '{4'hE, 8'h00, 8'h10, 8'h10, 8'h00, 4'b1001, 8'd9, 8'd8, 1'b0},
      '{4'hE, 8'h00, 8'h80, 8'hFF, 8'h80, 4'b0101, 8'd9, 8'd8, 1'b0}
    };
`else
    vec_t tbl [3] = '{
      '{4'hE, 8'h00, 8'h12, 8'h34, 8'h12, 4'b0000, 8'd1, 8'd0, 1'b0},
      '{4'hE, 8'h00, 8'h80, 8'hFF, 8'h80, 4'b0100, 8'd1, 8'd0, 1'b0},
      '{4'hE, 8'h00, 8'h00, 8'h10, 8'h00, 4'b1000, 8'd1, 8'd0, 1'b0}
    };
`endif
    for (int i = 0; i < 3; i++) begin
      do_op(tbl[i].op, tbl[i].imm, tbl[i].a, tbl[i].b, lat, bsy);
      vecs++;
      if ({alu_out, flags, 8'(lat), 8'(bsy)} !== {tbl[i].res, tbl[i].fl, tbl[i].lat, tbl[i].bsy}) begin
        errs++;
        $display("FAIL mul #%0d: out=%h flags=%b lat=%0d busy=%0d, expected out=%h flags=%b lat=%0d busy=%0d",
                 i, alu_out, flags, lat, bsy, tbl[i].res, tbl[i].fl, tbl[i].lat, tbl[i].bsy);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [11:0] ins  [3] = '{12'h200, 12'h300, 12'h600};
    logic [7:0]  a    [3] = '{8'h01, 8'h09, 8'hFF};
    logic [7:0]  b    [3] = '{8'h02, 8'h04, 8'h0F};
    logic [7:0]  eres [3] = '{8'h03, 8'h05, 8'hF0};
    logic [3:0]  efl  [3] = '{4'b0000, 4'b0010, 4'b0100};
    out_ready = 1'b1;
    @(negedge clk);
    instr = ins[0]; acc = a[0]; mem_data = b[0]; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (i < 2) begin
        instr = ins[i+1]; acc = a[i+1]; mem_data = b[i+1];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      vecs++;
      if ({out_valid, alu_out, flags} !== {1'b1, eres[i], efl[i]}) begin
        errs++;
        $display("FAIL back_to_back #%0d: valid=%b out=%h flags=%b, expected 1 %h %b",
                 i, out_valid, alu_out, flags, eres[i], efl[i]);
      end
    end
  endtask

  task automatic test_reset_mid_asrn;
    int lat, bsy;
    do_op(4'h2, 8'h00, 8'h7F, 8'h01, lat, bsy);
    @(negedge clk);
    instr = {4'hD, 8'h05}; acc = 8'h80; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    vecs++;
    if ({out_valid, alu_out, flags, we_alu} !== {1'b0, 8'h00, 4'h0, 1'b0}) begin
      errs++;
      $display("FAIL rst_mid_asrn: valid=%b out=%h flags=%b we=%b, expected all zero",
               out_valid, alu_out, flags, we_alu);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vecs++;
    if ({in_ready, out_valid, alu_out} !== {1'b1, 1'b0, 8'h00}) begin
      errs++;
      $display("FAIL rst_release: in_ready=%b valid=%b out=%h, expected 1 0 00", in_ready, out_valid, alu_out);
    end
    do_op(4'h2, 8'h00, 8'h01, 8'h01, lat, bsy);
    vecs++;
    if ({alu_out, flags, 8'(lat)} !== {8'h02, 4'b0000, 8'd1}) begin
      errs++;
      $display("FAIL op_after_rst: out=%h flags=%b lat=%0d, expected 02 0000 1", alu_out, flags, lat);
    end
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_asrn();
    test_backpressure();
    test_store();
    test_mul();
    test_back_to_back();
    test_reset_mid_asrn();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
